// File: rtl/mips_pkg.sv
// Shared constants and types for the multi-cycle MIPS controller.
// Holds the opcodes, the ALUOP classes, the MemRead modes, the state codes and the strobe bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [6:0] ALUOP_ADD   = 7'd0;
    localparam logic [6:0] ALUOP_SUB   = 7'd1;
    localparam logic [6:0] ALUOP_RTYPE = 7'd2;

    localparam logic [1:0] MEMREAD_NONE = 2'b00;
    localparam logic [1:0] MEMREAD_WORD = 2'b01;

    // Plain constants rather than an enum keep the encoding visible to legacy tools.
    typedef logic [3:0] state_t;
    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_EXEC_R   = 4'd2;
    localparam state_t S_EXEC_I   = 4'd3;
    localparam state_t S_MEM_ADDR = 4'd4;
    localparam state_t S_MEM_RD   = 4'd5;
    localparam state_t S_MEM_WR   = 4'd6;
    localparam state_t S_WB_R     = 4'd7;
    localparam state_t S_WB_I     = 4'd8;
    localparam state_t S_WB_MEM   = 4'd9;
    localparam state_t S_BRANCH   = 4'd10;
    localparam state_t S_JUMP     = 4'd11;
    localparam state_t S_TRAP     = 4'd12;

    typedef struct packed {
        logic       imem_req;
        logic       fetch_load;
        logic       pc_write;
        logic       reg_dst;
        logic       branch;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       jump;
        logic [6:0] alu_op;
        logic [1:0] mem_read;
        logic       trap;
    } ctrl_t;

endpackage

// File: rtl/ctrl_outdec.sv
// Purely combinational decoder from the controller state to the datapath strobes.
// fetch_load marks the fetch state; the top qualifies it with imem_ready for the IR and PC loads.
module ctrl_outdec
    import mips_pkg::*;
(
    input  logic [3:0] state,
    output ctrl_t      ctrl
);

    always_comb begin
        // NOTE: every field gets a default first, so no path through the case can infer a latch.
        ctrl          = '0;
        ctrl.alu_op   = ALUOP_ADD;
        ctrl.mem_read = MEMREAD_NONE;
        case (state)
            S_FETCH: begin
                ctrl.imem_req   = 1'b1;
                ctrl.fetch_load = 1'b1;
            end
            S_EXEC_R:   ctrl.alu_op = ALUOP_RTYPE;
            S_WB_R: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            S_EXEC_I:   ctrl.alu_src = 1'b1;
            S_WB_I: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_MEM_ADDR: ctrl.alu_src = 1'b1;
            S_MEM_RD: begin
                ctrl.alu_src  = 1'b1;
                ctrl.mem_read = MEMREAD_WORD;
            end
            S_WB_MEM: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = MEMREAD_WORD;
            end
            S_MEM_WR: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_SUB;
            end
            S_JUMP: begin
                ctrl.jump     = 1'b1;
                ctrl.pc_write = 1'b1;
            end
            S_TRAP:     ctrl.trap = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS controller: state register, next-state logic and retired-instruction counter.
// The strobes come from ctrl_outdec and are forced low while rst_n is asserted.
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             RegDst,
    output logic             Branch,
    output logic             MemtoReg,
    output logic             Memwrite,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic             Jump,
    output logic [6:0]       ALUOP,
    output logic [1:0]       MemRead,
    output logic             trap,
    output logic [CNT_W-1:0] instr_count
);

    state_t state;
    state_t state_nxt;
    logic   retire;
    ctrl_t  ctrl;

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            S_FETCH:    if (imem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_nxt = S_EXEC_R;
                    OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI:      state_nxt = S_EXEC_I;
                    default:      state_nxt = S_TRAP;
                endcase
            end
            S_EXEC_R:   state_nxt = S_WB_R;
            S_EXEC_I:   state_nxt = S_WB_I;
            // Only lw and sw reach here, so anything but lw is a store.
            S_MEM_ADDR: state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (dmem_ready) state_nxt = S_WB_MEM;
            S_MEM_WR: begin
                if (dmem_ready) begin
                    state_nxt = S_FETCH;
                    retire    = 1'b1;
                end
            end
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_TRAP:     state_nxt = S_TRAP;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (retire) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    ctrl_outdec u_outdec (
        .state (state),
        .ctrl  (ctrl)
    );

    // The IR and PC load only in the cycle the fetched word is valid.
    assign imem_req = rst_n & ctrl.imem_req;
    assign ir_write = rst_n & ctrl.fetch_load & imem_ready;
    assign pc_write = rst_n & (ctrl.pc_write | (ctrl.fetch_load & imem_ready));
    assign RegDst   = rst_n & ctrl.reg_dst;
    assign Branch   = rst_n & ctrl.branch;
    assign MemtoReg = rst_n & ctrl.mem_to_reg;
    assign Memwrite = rst_n & ctrl.mem_write;
    assign ALUSrc   = rst_n & ctrl.alu_src;
    assign RegWrite = rst_n & ctrl.reg_write;
    assign Jump     = rst_n & ctrl.jump;
    assign ALUOP    = rst_n ? ctrl.alu_op : 7'd0;
    assign MemRead  = rst_n ? ctrl.mem_read : 2'b00;
    assign trap     = rst_n & ctrl.trap;

endmodule
